mwadd_seq: RTL and testbench

Sequential multi-word adder. It sits directly upstream of the 16-bit carry-lookahead adder slice and owns it. It accepts two wide operands over a valid/ready handshake, then feeds them to the slice one 16-bit chunk per cycle, least-significant chunk first. The slice's carry-out is registered between chunks. The full sum is presented on a held output handshake. It replaces a combinational WORDS-wide lookahead tree with one slice plus a small FSM.

---
 rtl/adder_pkg.sv | 12 +
 rtl/mwadd_seq_if.sv | 38 +++
 rtl/mwadd_seq_add16_slice.sv | 29 ++
 rtl/mwadd_seq.sv | 104 ++++++++++
 tb/tb_mwadd_seq.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared chunk width, FSM state and chunk type for the multi-word adder
package adder_pkg;
    localparam int CHUNK = 16;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef logic [0:CHUNK-1] chunk_t;
endpackage

// File: rtl/mwadd_seq_if.sv
// rtl/mwadd_seq_if.sv - operand/result handshake bundle for mwadd_seq; sub exists only with MWADD_SUB_EN
interface mwadd_seq_if #(
    parameter int WORDS = 4
);
    localparam int W = 16 * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [0:W-1] a;
    logic [0:W-1] b;
    logic         cin;
`ifdef MWADD_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [0:W-1] sum;
    logic         cout;
    logic         ovf;

    modport slave (
        input  in_valid, a, b, cin,
`ifdef MWADD_SUB_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

    modport master (
        output in_valid, a, b, cin,
`ifdef MWADD_SUB_EN
        output sub,
`endif
        output out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/mwadd_seq_add16_slice.sv
// rtl/mwadd_seq_add16_slice.sv - 16-bit carry-lookahead slice; index 0 is the LSB
module add16_slice
    import adder_pkg::*;
(
    output logic   G,
    output logic   P,
    output chunk_t sum,
    input  logic   cin,
    input  chunk_t a,
    input  chunk_t b
);
    logic gg;
    logic pp;

    // Each bit's carry comes from the group G/P of all lower bits plus cin,
    // never from the previous bit's carry signal.
    always_comb begin
        sum = '0;
        gg  = 1'b0;
        pp  = 1'b1;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i] = (a[i] ^ b[i]) ^ (gg | (pp & cin));
            gg     = (a[i] & b[i]) | ((a[i] ^ b[i]) & gg);
            pp     = pp & (a[i] ^ b[i]);
        end
        G = gg;
        P = pp;
    end
endmodule

// File: rtl/mwadd_seq.sv
// rtl/mwadd_seq.sv - sequential WORDS x 16-bit adder around one lookahead slice; MWADD_SUB_EN adds subtract
module mwadd_seq
    import adder_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        nrst,
    mwadd_seq_if.slave  bus
);
    localparam int W  = CHUNK * WORDS;
    localparam int KW = $clog2(WORDS);

    state_t         state_q;
    state_t         state_d;
    logic [KW-1:0]  k_q;
    logic [KW+3:0]  base;
    logic [0:W-1]   a_q;
    logic [0:W-1]   b_q;
    logic [0:W-1]   sum_q;
    logic           carry_q;
    logic           cout_q;
    logic           ovf_q;
    logic           sub_in;
    logic           last;
    logic           slice_g;
    logic           slice_p;
    logic           slice_cout;
    chunk_t         slice_sum;

`ifdef MWADD_SUB_EN
    assign sub_in = bus.sub;
`else
    assign sub_in = 1'b0;
`endif

    assign base = {k_q, 4'b0000};
    assign last = (k_q == KW'(WORDS - 1));

    add16_slice u_slice (
        .G   (slice_g),
        .P   (slice_p),
        .sum (slice_sum),
        .cin (carry_q),
        .a   (a_q[base +: CHUNK]),
        .b   (b_q[base +: CHUNK])
    );

    assign slice_cout = slice_g | (slice_p & carry_q);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = BUSY;
            BUSY:    if (last)          state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Subtraction stores ~B and forces the carry-in so the slice computes A + ~B + 1.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    a_q     <= bus.a;
                    b_q     <= sub_in ? ~bus.b : bus.b;
                    carry_q <= sub_in | bus.cin;
                    k_q     <= '0;
                end
                BUSY: begin
                    sum_q[base +: CHUNK] <= slice_sum;
                    carry_q              <= slice_cout;
                    k_q                  <= k_q + KW'(1);
                    if (last) begin
                        cout_q <= slice_cout;
                        // a^b^s at the MSB recovers the carry into bit W-1
                        ovf_q  <= a_q[W-1] ^ b_q[W-1] ^ slice_sum[CHUNK-1] ^ slice_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_mwadd_seq.sv
// tb/tb_mwadd_seq.sv - directed vector bench for mwadd_seq (WORDS=4); MWADD_SUB_EN adds subtract vectors
module tb_mwadd_seq;
    logic clk = 1'b0;
    logic nrst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mwadd_seq_if #(.WORDS(4)) bus ();
    mwadd_seq #(.WORDS(4)) dut (.clk(clk), .nrst(nrst), .bus(bus));

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    // Bus vectors are [0:63] with index 0 as LSB; bench values are ordinary numbers.
    function automatic logic [0:63] to_bus(input logic [63:0] v);
        logic [0:63] r;
        for (int i = 0; i < 64; i++) r[i] = v[i];
        return r;
    endfunction

    function automatic logic [63:0] from_bus(input logic [0:63] v);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = v[i];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input vec_t v, input int hold, input bit toggle);
        int cyc;
        @(negedge clk);
        check({tag, " in_ready idle"}, 64'(bus.in_ready), 64'd1);
        bus.a   = to_bus(v.a);
        bus.b   = to_bus(v.b);
        bus.cin = v.cin;
`ifdef MWADD_SUB_EN
        bus.sub = v.sub;
`endif
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            if (toggle) begin
                bus.a   = to_bus(v.a ^ {16'(cyc + 1), 48'h5A5A_F0F0_1234});
                bus.b   = ~bus.b;
                bus.cin = ~bus.cin;
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check({tag, " latency"}, 64'(cyc), 64'd4);
        check({tag, " sum"}, from_bus(bus.sum), v.sum);
        check({tag, " cout"}, 64'(bus.cout), 64'(v.cout));
        check({tag, " ovf"}, 64'(bus.ovf), 64'(v.ovf));
        for (int i = 0; i < hold; i++) begin
            bus.a = to_bus(~v.a);
            @(posedge clk);
            @(negedge clk);
            check({tag, " hold sum"}, from_bus(bus.sum), v.sum);
            check({tag, " hold cout"}, 64'(bus.cout), 64'(v.cout));
            check({tag, " hold ovf"}, 64'(bus.ovf), 64'(v.ovf));
            check({tag, " hold in_ready"}, 64'(bus.in_ready), 64'd0);
            check({tag, " hold out_valid"}, 64'(bus.out_valid), 64'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, " out_valid drop"}, 64'(bus.out_valid), 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
        check({tag, " out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, " sum"}, from_bus(bus.sum), 64'd0);
        check({tag, " cout"}, 64'(bus.cout), 64'd0);
        check({tag, " ovf"}, 64'(bus.ovf), 64'd0);
    endtask

    vec_t vecs[$];
    vec_t v;

    initial begin
        nrst          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
`ifdef MWADD_SUB_EN
        bus.sub       = 1'b0;
`endif
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0});
        vecs.push_back('{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0});
        vecs.push_back('{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1});
        vecs.push_back('{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1});
        vecs.push_back('{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 64'h2222_2222_2222_2211, 1'b0, 1'b0});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0});
        vecs.push_back('{64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0});
`ifdef MWADD_SUB_EN
        vecs.push_back('{64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0});
        vecs.push_back('{64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0});
`endif

        repeat (2) @(negedge clk);
        check_reset_values("reset");
        nrst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_op($sformatf("vec%0d", i), vecs[i], 0, 1'b0);
        end

        // Backpressure with operand churn during BUSY and DONE
        run_op("bp", vecs[4], 5, 1'b1);

        // Abort after chunk 1: two BUSY edges, then asynchronous reset mid-cycle
        @(negedge clk);
        bus.a        = to_bus(64'hFFFF_FFFF_FFFF_FFFF);
        bus.b        = to_bus(64'h1);
        bus.cin      = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        nrst = 1'b0;
        #1;
        check_reset_values("abort");
        @(negedge clk);
        nrst = 1'b1;
        v = '{64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0};
        run_op("after_abort", v, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
